// File: rtl/lbp_pkg.sv
// Shared types and defaults for the LBP scan controller.
package lbp_pkg;

  localparam int LBP_IMG_W = 128;
  localparam int LBP_IMG_H = 128;
  localparam int LBP_AW    = 14;

  typedef enum logic [2:0] {
    IDLE, FILL, SHIFT, WAITD, CALC, WRITE, DONE
  } lbp_state_e;

  // Window slots, row-major: T/M/B row, L/C/R column.
  localparam logic [3:0] SLOT_TL = 4'd0;
  localparam logic [3:0] SLOT_TC = 4'd1;
  localparam logic [3:0] SLOT_TR = 4'd2;
  localparam logic [3:0] SLOT_ML = 4'd3;
  localparam logic [3:0] SLOT_C  = 4'd4;
  localparam logic [3:0] SLOT_MR = 4'd5;
  localparam logic [3:0] SLOT_BL = 4'd6;
  localparam logic [3:0] SLOT_BC = 4'd7;
  localparam logic [3:0] SLOT_BR = 4'd8;

endpackage

// File: rtl/lbp_win_addr.sv
// Maps a window centre (x, y) and slot 0..8 to the gray-memory address of
// that neighbour. IMG_W is a power of two, so y*IMG_W+x is a concatenation.
module lbp_win_addr import lbp_pkg::*; #(
  parameter int IMG_W = LBP_IMG_W,
  parameter int AW    = LBP_AW,
  localparam int XW   = $clog2(IMG_W),
  localparam int YW   = AW - XW
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [3:0]    slot,
  output logic [AW-1:0] addr
);

  logic [1:0]    dr, dc;
  logic [YW-1:0] row;
  logic [XW-1:0] col;

  always_comb begin
    {dr, dc} = {2'd1, 2'd1};
    case (slot)
      SLOT_TL: {dr, dc} = {2'd0, 2'd0};
      SLOT_TC: {dr, dc} = {2'd0, 2'd1};
      SLOT_TR: {dr, dc} = {2'd0, 2'd2};
      SLOT_ML: {dr, dc} = {2'd1, 2'd0};
      SLOT_C:  {dr, dc} = {2'd1, 2'd1};
      SLOT_MR: {dr, dc} = {2'd1, 2'd2};
      SLOT_BL: {dr, dc} = {2'd2, 2'd0};
      SLOT_BC: {dr, dc} = {2'd2, 2'd1};
      SLOT_BR: {dr, dc} = {2'd2, 2'd2};
      default: {dr, dc} = {2'd1, 2'd1};
    endcase
    row  = y + YW'(dr) - YW'(1);
    col  = x + XW'(dc) - XW'(1);
    addr = {row, col};
  end

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster-order scan sequencer for the LBP 3x3 window datapath.
// LBP_BORDER_WRITE_EN adds zero-valued writes for every border pixel.
module lbp_scan_ctrl import lbp_pkg::*; #(
  parameter int IMG_W = LBP_IMG_W,
  parameter int IMG_H = LBP_IMG_H,
  parameter int AW    = LBP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  output logic          pix_we,
  output logic [3:0]    pix_slot,
  output logic          win_shift,
  output logic          calc_start,
  input  logic          calc_done,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_valid,
`ifdef LBP_BORDER_WRITE_EN
  output logic          lbp_zero,
`endif
  output logic          finish
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = AW - XW;
`ifdef LBP_BORDER_WRITE_EN
  localparam logic [XW-1:0] X0 = '0;
  localparam logic [YW-1:0] Y0 = '0;
`else
  localparam logic [XW-1:0] X0 = XW'(1);
  localparam logic [YW-1:0] Y0 = YW'(1);
`endif

  lbp_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pix_we_q, win_shift_q, win_shift_d, calc_start_q, calc_start_d;
  logic          lbp_valid_q, lbp_valid_d, finish_q, finish_d;
  logic [3:0]    pix_slot_q, rd_slot;
  logic [AW-1:0] lbp_addr_q, lbp_addr_d, win_addr;
  logic          rd_active;

  // SHIFT spends cnt 0 on the window shift, cnt 1..3 on the new right column.
  always_comb begin
    rd_slot = '0;
    if (state_q == FILL) rd_slot = cnt_q;
    else if (state_q == SHIFT) begin
      case (cnt_q)
        4'd1:    rd_slot = SLOT_TR;
        4'd2:    rd_slot = SLOT_MR;
        4'd3:    rd_slot = SLOT_BR;
        default: rd_slot = '0;
      endcase
    end
  end

  assign rd_active = (state_q == FILL) || (state_q == SHIFT && cnt_q != 4'd0);
  assign gray_req  = rd_active && gray_ready;

  lbp_win_addr #(.IMG_W(IMG_W), .AW(AW)) u_win_addr (
    .x(x_q), .y(y_q), .slot(rd_slot), .addr(win_addr)
  );

  assign gray_addr = gray_req ? win_addr : '0;

`ifdef LBP_BORDER_WRITE_EN
  logic          zero_q, zero_d, last_col, nb;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  always_comb begin
    last_col = (x_q == XW'(IMG_W-1));
    nx = last_col ? '0 : x_q + XW'(1);
    ny = last_col ? y_q + YW'(1) : y_q;
    nb = (ny == '0) || (ny == YW'(IMG_H-1)) || (nx == '0) || (nx == XW'(IMG_W-1));
  end
  assign lbp_zero = zero_q;
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    win_shift_d  = 1'b0;
    calc_start_d = 1'b0;
    lbp_valid_d  = 1'b0;
    lbp_addr_d   = lbp_addr_q;
`ifdef LBP_BORDER_WRITE_EN
    zero_d       = 1'b0;
`endif
    case (state_q)
      IDLE: if (gray_ready) begin
`ifdef LBP_BORDER_WRITE_EN
        state_d     = WRITE;
        lbp_valid_d = 1'b1;
        lbp_addr_d  = {y_q, x_q};
        zero_d      = 1'b1;
`else
        state_d = FILL;
        cnt_d   = '0;
`endif
      end
      FILL: if (gray_ready) begin
        if (cnt_q == SLOT_BR) begin
          state_d = WAITD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 4'd1;
      end
      SHIFT: begin
        if (cnt_q == 4'd0) cnt_d = 4'd1;
        else if (gray_ready) begin
          if (cnt_q == 4'd3) begin
            state_d = WAITD;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end
      end
      WAITD: begin
        state_d      = CALC;
        calc_start_d = 1'b1;
      end
      // A done coincident with calc_start belongs to an older result.
      CALC: if (calc_done && !calc_start_q) begin
        state_d     = WRITE;
        lbp_valid_d = 1'b1;
        lbp_addr_d  = {y_q, x_q};
      end
      WRITE: begin
`ifdef LBP_BORDER_WRITE_EN
        if (last_col && y_q == YW'(IMG_H-1)) state_d = DONE;
        else begin
          x_d   = nx;
          y_d   = ny;
          cnt_d = '0;
          if (nb) begin
            state_d     = WRITE;
            lbp_valid_d = 1'b1;
            lbp_addr_d  = {ny, nx};
            zero_d      = 1'b1;
          end else if (nx == XW'(1)) state_d = FILL;
          else begin
            state_d     = SHIFT;
            win_shift_d = 1'b1;
          end
        end
`else
        if (x_q < XW'(IMG_W-2)) begin
          x_d         = x_q + XW'(1);
          state_d     = SHIFT;
          cnt_d       = '0;
          win_shift_d = 1'b1;
        end else if (y_q < YW'(IMG_H-2)) begin
          x_d     = XW'(1);
          y_d     = y_q + YW'(1);
          state_d = FILL;
          cnt_d   = '0;
        end else state_d = DONE;
`endif
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    finish_d = finish_q || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= X0;
      y_q          <= Y0;
      cnt_q        <= '0;
      pix_we_q     <= 1'b0;
      pix_slot_q   <= '0;
      win_shift_q  <= 1'b0;
      calc_start_q <= 1'b0;
      lbp_valid_q  <= 1'b0;
      lbp_addr_q   <= '0;
      finish_q     <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      pix_we_q     <= gray_req;
      pix_slot_q   <= rd_slot;
      win_shift_q  <= win_shift_d;
      calc_start_q <= calc_start_d;
      lbp_valid_q  <= lbp_valid_d;
      lbp_addr_q   <= lbp_addr_d;
      finish_q     <= finish_d;
`ifdef LBP_BORDER_WRITE_EN
      zero_q       <= zero_d;
`endif
    end
  end

  assign pix_we     = pix_we_q;
  assign pix_slot   = pix_slot_q;
  assign win_shift  = win_shift_q;
  assign calc_start = calc_start_q;
  assign lbp_valid  = lbp_valid_q;
  assign lbp_addr   = lbp_addr_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl: a default 128x128 instance for sequencing detail
// and a 16x8 instance small enough to scan completely.
module tb_lbp_scan_ctrl;
  localparam int BW = 128, BH = 128, BA = 14;
  localparam int SW = 16,  SH = 8,   SA = 7;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic          b_ready = 1'b0, b_done = 1'b0, b_req, b_we, b_shift, b_cs, b_valid, b_fin;
  logic [BA-1:0] b_addr, b_laddr;
  logic [3:0]    b_slot;
  logic          s_ready = 1'b0, s_done = 1'b0, s_req, s_we, s_shift, s_cs, s_valid, s_fin;
  logic [SA-1:0] s_addr, s_laddr;
  logic [3:0]    s_slot;
`ifdef LBP_BORDER_WRITE_EN
  logic          b_zero, s_zero;
`endif

  lbp_scan_ctrl #(.IMG_W(BW), .IMG_H(BH), .AW(BA)) u_big (
    .clk(clk), .reset(reset), .gray_ready(b_ready), .gray_req(b_req), .gray_addr(b_addr),
    .pix_we(b_we), .pix_slot(b_slot), .win_shift(b_shift), .calc_start(b_cs),
    .calc_done(b_done), .lbp_addr(b_laddr), .lbp_valid(b_valid),
`ifdef LBP_BORDER_WRITE_EN
    .lbp_zero(b_zero),
`endif
    .finish(b_fin));

  lbp_scan_ctrl #(.IMG_W(SW), .IMG_H(SH), .AW(SA)) u_small (
    .clk(clk), .reset(reset), .gray_ready(s_ready), .gray_req(s_req), .gray_addr(s_addr),
    .pix_we(s_we), .pix_slot(s_slot), .win_shift(s_shift), .calc_start(s_cs),
    .calc_done(s_done), .lbp_addr(s_laddr), .lbp_valid(s_valid),
`ifdef LBP_BORDER_WRITE_EN
    .lbp_zero(s_zero),
`endif
    .finish(s_fin));

  typedef struct { int addr; int slot; } rd_t;
  rd_t exp_rd[$];
  int  exp_wr[$];
  int  vectors = 0, miscompares = 0;

  // Datapath stand-in. Mode 0: done one cycle after calc_start;
  // 1: done only in the calc_start cycle; 2: done held high.
  int   done_mode = 0;
  logic b_cs_seen = 1'b0, s_cs_seen = 1'b0;
  always @(negedge clk) begin
    b_cs_seen = b_cs;
    s_cs_seen = s_cs;
  end
  always @(posedge clk) begin
    #1;
    case (done_mode)
      1:       b_done = b_cs;
      2:       b_done = 1'b1;
      default: b_done = b_cs_seen;
    endcase
    s_done = s_cs_seen;
  end

  task automatic do_reset();
    b_ready = 1'b0;
    s_ready = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Reference scan: raster over interior centres; 9 reads at row start, else
  // the 3 reads of the new right column.
  task automatic push_windows(input int w, input int h, input int nmax);
    int n = 0;
    exp_rd.delete();
    exp_wr.delete();
    for (int y = 1; y <= h - 2; y++)
      for (int x = 1; x <= w - 2; x++)
        if (n < nmax) begin
          if (x == 1)
            for (int s = 0; s < 9; s++) exp_rd.push_back('{addr: (y - 1 + s / 3) * w + x - 1 + s % 3, slot: s});
          else
            for (int r = 0; r < 3; r++) exp_rd.push_back('{addr: (y - 1 + r) * w + x + 1, slot: 3 * r + 2});
          exp_wr.push_back(y * w + x);
          n++;
        end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    vectors++;
    if ({b_req, b_addr, b_we, b_slot, b_shift, b_cs, b_laddr, b_valid, b_fin} !== '0) begin
      miscompares++;
      $display("FAIL reset_big: outputs=%h want 0", {b_req, b_addr, b_we, b_slot, b_shift, b_cs, b_laddr, b_valid, b_fin});
    end
    vectors++;
    if ({s_req, s_addr, s_we, s_slot, s_shift, s_cs, s_laddr, s_valid, s_fin} !== '0) begin
      miscompares++;
      $display("FAIL reset_small: outputs=%h want 0", {s_req, s_addr, s_we, s_slot, s_shift, s_cs, s_laddr, s_valid, s_fin});
    end
    b_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({b_req, b_we, b_cs, b_valid, b_fin} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_hold: req/we/cs/valid/fin=%b want 00000", {b_req, b_we, b_cs, b_valid, b_fin});
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    rd_t  e;
    int   ps = 0, nsh = 0, cyc = 0;
    logic pr = 1'b0;
    do_reset();
    push_windows(BW, BH, 128);
    b_ready = 1'b1;
    while (exp_wr.size() > 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      vectors++;
      if (b_we !== pr || (pr && b_slot !== 4'(ps))) begin
        miscompares++;
        $display("FAIL scan_pix: we=%b slot=%0d want we=%b slot=%0d", b_we, b_slot, pr, ps);
      end
      pr = b_req;
      if (b_req) begin
        vectors++;
        if (exp_rd.size() == 0) begin
          miscompares++;
          $display("FAIL scan_rd_extra: addr=%0d want no request", b_addr);
        end else begin
          e  = exp_rd.pop_front();
          ps = e.slot;
          if (b_addr !== BA'(e.addr)) begin
            miscompares++;
            $display("FAIL scan_rd_addr: got %0d want %0d (slot %0d)", b_addr, e.addr, e.slot);
          end
        end
      end
      if (b_shift) begin
        nsh++;
        vectors++;
        if (b_req !== 1'b0) begin
          miscompares++;
          $display("FAIL scan_shift_req: req=%b during win_shift want 0", b_req);
        end
      end
      if (b_valid) begin
        vectors++;
        if (b_laddr !== BA'(exp_wr[0])) begin
          miscompares++;
          $display("FAIL scan_lbp_addr: got %0d want %0d", b_laddr, exp_wr[0]);
        end
        void'(exp_wr.pop_front());
      end
    end
    vectors++;
    if (exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL scan_timeout: %0d writes outstanding want 0", exp_wr.size());
    end
    vectors++;
    if (nsh != 126) begin
      miscompares++;
      $display("FAIL scan_shift_count: got %0d want 126", nsh);
    end
  endtask

  task automatic test_stall();
    int   first9[9] = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
    int   idx = 0, drop = 0, cyc = 0, ps = 0;
    logic pr = 1'b0;
    do_reset();
    b_ready = 1'b1;
    while (idx < 9 && cyc < 200) begin
      @(posedge clk); #1;
      b_ready = (drop == 0);
      if (drop > 0) drop--;
      @(negedge clk);
      cyc++;
      vectors++;
      if (b_we !== pr || (pr && b_slot !== 4'(ps))) begin
        miscompares++;
        $display("FAIL stall_pix: we=%b slot=%0d want we=%b slot=%0d", b_we, b_slot, pr, ps);
      end
      pr = b_req;
      if (!b_ready) begin
        vectors++;
        if (b_req !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_req: req=%b while not ready want 0", b_req);
        end
      end else if (b_req) begin
        vectors++;
        if (b_addr !== BA'(first9[idx])) begin
          miscompares++;
          $display("FAIL stall_addr: read %0d got %0d want %0d", idx, b_addr, first9[idx]);
        end
        ps = idx;
        idx++;
        if (idx == 4) drop = 5;
      end
    end
    vectors++;
    if (idx != 9) begin
      miscompares++;
      $display("FAIL stall_timeout: %0d reads want 9", idx);
    end
    cyc = 0;
    while (!b_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (b_valid !== 1'b1 || b_laddr !== BA'(129)) begin
      miscompares++;
      $display("FAIL stall_first_write: valid=%b addr=%0d want 1/129", b_valid, b_laddr);
    end
  endtask

  task automatic test_done_gate();
    int cyc = 0, seen = 0;
    do_reset();
    done_mode = 1;
    b_ready = 1'b1;
    while (!b_cs && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (b_valid) seen++;
    end
    vectors++;
    if (!b_cs || seen != 0) begin
      miscompares++;
      $display("FAIL gate_start: calc_start=%b early writes=%0d want 1/0", b_cs, seen);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL gate_same_cycle: %0d writes want 0", seen);
    end
    done_mode = 2;
    cyc = 0;
    while (!b_valid && cyc < 5) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (b_valid !== 1'b1 || b_laddr !== BA'(129)) begin
      miscompares++;
      $display("FAIL gate_accept: valid=%b addr=%0d want 1/129", b_valid, b_laddr);
    end
    // With done held high, the write still lands two cycles after calc_start.
    cyc = 0;
    seen = 0;
    @(negedge clk);
    while (!b_cs && cyc < 50) begin
      if (b_valid) seen++;
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    if (b_valid) seen++;
    @(negedge clk);
    vectors++;
    if (seen != 0 || b_valid !== 1'b1 || b_laddr !== BA'(130)) begin
      miscompares++;
      $display("FAIL gate_held: early=%0d valid=%b addr=%0d want 0/1/130", seen, b_valid, b_laddr);
    end
    done_mode = 0;
  endtask

  task automatic test_reset_mid();
    int cyc = 0, ncs = 0, bad = 0;
    do_reset();
    b_ready = 1'b1;
    while (ncs < 2 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (b_cs) ncs++;
    end
    @(posedge clk); #1;
    vectors++;
    if (ncs != 2 || b_laddr !== BA'(129)) begin
      miscompares++;
      $display("FAIL mid_pre: calc_starts=%0d lbp_addr=%0d want 2/129", ncs, b_laddr);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({b_req, b_addr, b_we, b_slot, b_shift, b_cs, b_laddr, b_valid, b_fin} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: outputs=%h want 0", {b_req, b_addr, b_we, b_slot, b_shift, b_cs, b_laddr, b_valid, b_fin});
    end
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!b_req && cyc < 20) begin
      if (b_valid) bad++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (b_req !== 1'b1 || b_addr !== '0 || bad != 0) begin
      miscompares++;
      $display("FAIL mid_restart: req=%b addr=%0d stray writes=%0d want 1/0/0", b_req, b_addr, bad);
    end
  endtask

  task automatic test_full_image();
    rd_t e;
    int  nwr = 0, last = -1, wr_cyc = -1, fin_cyc = -1, cyc = 0, bad = 0;
    do_reset();
    push_windows(SW, SH, 100000);
    s_ready = 1'b1;
    while (fin_cyc < 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (s_req) begin
        vectors++;
        if (exp_rd.size() == 0) begin
          miscompares++;
          $display("FAIL full_rd_extra: addr=%0d want no request", s_addr);
        end else begin
          e = exp_rd.pop_front();
          if (s_addr !== SA'(e.addr)) begin
            miscompares++;
            $display("FAIL full_rd_addr: got %0d want %0d", s_addr, e.addr);
          end
        end
      end
      if (s_valid) begin
        vectors++;
        if (exp_wr.size() == 0 || s_laddr !== SA'(exp_wr[0])) begin
          miscompares++;
          $display("FAIL full_lbp_addr: got %0d want %0d", s_laddr, exp_wr.size() ? exp_wr[0] : -1);
        end
        if (exp_wr.size() != 0) void'(exp_wr.pop_front());
        nwr++;
        last = int'(s_laddr);
        wr_cyc = cyc;
      end
      if (s_fin) fin_cyc = cyc;
    end
    vectors++;
    if (nwr != 84 || last != 110) begin
      miscompares++;
      $display("FAIL full_count: writes=%0d last=%0d want 84/110", nwr, last);
    end
    vectors++;
    if (fin_cyc != wr_cyc + 1 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL full_finish: finish cycle=%0d last write=%0d reads left=%0d want +1/0", fin_cyc, wr_cyc, exp_rd.size());
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_fin !== 1'b1 || s_req || s_valid || s_cs || s_shift) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL full_hold: %0d bad cycles after finish want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_stall();
    test_done_gate();
    test_reset_mid();
    test_full_image();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
